approx_adder_pipe: RTL and testbench

APPROX_ADDER_PIPE -- requirements
Module: approx_adder_pipe

---
 rtl/approx_adder_pipe.sv | 164 ++++++++++++++++
 tb/tb_approx_adder_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: segmented, valid/ready pipelined adder with an optional
// approximate carry chain across the lowest APPROX_SEGS segments.
// Optional feature macro: APPROX_ADDER_ERRCNT_EN adds err/err_cnt/clr and
// an exact reference sum that travels with each transaction.

// One segment adder. In approximate mode the carry handed upward is the
// MSB generate term instead of the real carry-out.
module approx_adder_seg #(
    parameter int SEG    = 8,
    parameter bit APPROX = 1'b0
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           cin,
    input  logic           mode,
    output logic [SEG-1:0] s,
    output logic           cnext
);
    logic [SEG:0] full;

    assign full  = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, cin};
    assign s     = full[SEG-1:0];
    assign cnext = (APPROX && mode) ? (a_seg[SEG-1] & b_seg[SEG-1]) : full[SEG];
endmodule

module approx_adder_pipe #(
    parameter int W           = 32,
    parameter int SEG         = 8,
    parameter int APPROX_SEGS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef APPROX_ADDER_ERRCNT_EN
    ,
    output logic         err,
    output logic [15:0]  err_cnt,
    input  logic         clr
`endif
);
    localparam int NSEG = W / SEG;

    // Stage k registers hold the transaction after segment k has been added.
    // Operands are stored pre-shifted so the next unprocessed segment always
    // sits in the low SEG bits.
    logic [NSEG-1:0]          vld_pipe;
    logic [NSEG-1:0][W-1:0]   a_q, b_q, s_q;
    logic [NSEG-1:0]          c_q, m_q;

    // Stage inputs: ports for stage 0, previous stage registers otherwise.
    logic [NSEG-1:0][W-1:0]   a_in, b_in, s_in, s_new;
    logic [NSEG-1:0]          c_in, m_in, v_in, c_nx;
    logic [NSEG-1:0][SEG-1:0] seg_sum;
    logic [NSEG-1:0]          rdy;

`ifdef APPROX_ADDER_ERRCNT_EN
    logic [NSEG-1:0][W:0]     r_q, r_in;
`endif

    genvar k;
    generate
        for (k = 0; k < NSEG; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign a_in[k] = a;
                assign b_in[k] = b;
                assign s_in[k] = '0;
                assign c_in[k] = cin;
                assign m_in[k] = mode;
                assign v_in[k] = in_valid;
`ifdef APPROX_ADDER_ERRCNT_EN
                assign r_in[k] = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`endif
            end else begin : g_next
                assign a_in[k] = a_q[k-1];
                assign b_in[k] = b_q[k-1];
                assign s_in[k] = s_q[k-1];
                assign c_in[k] = c_q[k-1];
                assign m_in[k] = m_q[k-1];
                assign v_in[k] = vld_pipe[k-1];
`ifdef APPROX_ADDER_ERRCNT_EN
                assign r_in[k] = r_q[k-1];
`endif
            end

            // Stage k can load when the downstream side drains or any stage
            // from k upward is empty (closed form of !valid_k | ready_k+1).
            assign rdy[k] = out_ready | ~(&vld_pipe[NSEG-1:k]);

            approx_adder_seg #(
                .SEG    (SEG),
                .APPROX (k < APPROX_SEGS)
            ) u_seg (
                .a_seg (a_in[k][SEG-1:0]),
                .b_seg (b_in[k][SEG-1:0]),
                .cin   (c_in[k]),
                .mode  (m_in[k]),
                .s     (seg_sum[k]),
                .cnext (c_nx[k])
            );

            // Not-yet-computed sum bits are zero, so OR-ing places the segment.
            assign s_new[k] = s_in[k] | (W'(seg_sum[k]) << (k * SEG));
        end
    endgenerate

    // Pipeline registers: each stage advances when its ready is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s_q      <= '0;
            c_q      <= '0;
        end else begin
            for (int i = 0; i < NSEG; i++) begin
                if (rdy[i]) begin
                    vld_pipe[i] <= v_in[i];
                    if (v_in[i]) begin
                        a_q[i] <= a_in[i] >> SEG;
                        b_q[i] <= b_in[i] >> SEG;
                        m_q[i] <= m_in[i];
                        s_q[i] <= s_new[i];
                        c_q[i] <= c_nx[i];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[NSEG-1];
    assign sum       = s_q[NSEG-1];
    assign cout      = c_q[NSEG-1];

    // Last-stage operand/mode copies have no consumer.
    logic unused_tail;
    assign unused_tail = ^{a_q[NSEG-1], b_q[NSEG-1], m_q[NSEG-1]};

`ifdef APPROX_ADDER_ERRCNT_EN
    // Exact reference sum rides alongside the transaction.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSEG; i++) begin
            if (rdy[i] && v_in[i]) r_q[i] <= r_in[i];
        end
    end

    assign err = out_valid && ({cout, sum} != r_q[NSEG-1]);

    // Saturating count of erroneous results actually consumed downstream.
    always_ff @(posedge clk) begin
        if (rst || clr)
            err_cnt <= '0;
        else if (out_valid && out_ready && err && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_approx_adder_pipe.sv
// Self-checking bench for approx_adder_pipe (W=32, SEG=8, APPROX_SEGS=1).
// Covers APPROX_ADDER_ERRCNT_EN checks when that macro is defined.
module tb_approx_adder_pipe;
    localparam int W = 32, SEG = 8, AS = 1, NSEG = 4;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, mode, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
`ifdef APPROX_ADDER_ERRCNT_EN
    logic         err, clr;
    logic [15:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    approx_adder_pipe #(.W(W), .SEG(SEG), .APPROX_SEGS(AS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef APPROX_ADDER_ERRCNT_EN
        , .err(err), .err_cnt(err_cnt), .clr(clr)
`endif
    );

    typedef struct {
        logic [31:0] a, b;
        logic        cin, mode;
        logic [31:0] s;
        logic        c;
    } vec_t;

    typedef struct {
        logic [32:0] res;
        logic [32:0] exact;
    } exp_t;

    exp_t q[$];
    int   pass_cnt = 0, chk_cnt = 0, rcv = 0, err_exp = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: low AS byte-segments wrap independently and hand up only
    // their MSB-generate bit; the remaining upper part is an ordinary add.
    function automatic logic [32:0] model(logic [31:0] x, logic [31:0] y, logic ci, logic md);
        logic [63:0] r, c, sa, sb, hi;
        if (!md) begin
            r = 64'(x) + 64'(y) + 64'(ci);
            return r[32:0];
        end
        r = 0;
        c = 64'(ci);
        for (int k = 0; k < AS; k++) begin
            sa = (64'(x) >> (8 * k)) & 64'hFF;
            sb = (64'(y) >> (8 * k)) & 64'hFF;
            r  = r | (((sa + sb + c) & 64'hFF) << (8 * k));
            c  = (sa >> 7) & (sb >> 7);
        end
        hi = (64'(x) >> (8 * AS)) + (64'(y) >> (8 * AS)) + c;
        r  = r | (hi << (8 * AS));
        return r[32:0];
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: v = 32'hFFFF_FFFF ^ (32'h1 << $urandom_range(0, 31));
            2: begin
                case ($urandom_range(0, 3))
                    0: v[7:0] = 8'hFF;
                    1: v[7:0] = 8'h80;
                    2: v[7:0] = 8'h7F;
                    default: v[7:0] = 8'h00;
                endcase
            end
            default: v = 32'($urandom_range(0, 300));
        endcase
        return v;
    endfunction

    // Scoreboard: expectations pushed at accept, popped at output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            err_exp = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("result", {cout, sum}, e.res);
                    rcv++;
`ifdef APPROX_ADDER_ERRCNT_EN
                    chk("err", err, e.res != e.exact);
                    if (e.res != e.exact && err_exp < 65535) err_exp++;
`endif
                end
            end
            if (in_valid && in_ready) begin
                e.res   = model(a, b, cin, mode);
                e.exact = model(a, b, cin, 1'b0);
                q.push_back(e);
            end
        end
    end

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic md);
        a = x; b = y; cin = ci; mode = md;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(posedge clk); #1;
        drive(v.a, v.b, v.cin, v.mode);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("vec_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
        chk("vec_latency", n, NSEG);
        chk("vec_sum", sum, v.s);
        chk("vec_cout", cout, v.c);
    endtask

    vec_t tbl[10];
    logic [31:0] va[8], vb[8];
    logic        vm[8];
    int          idx, rcv0;
    logic        fire;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; mode = 1'b0;
`ifdef APPROX_ADDER_ERRCNT_EN
        clr = 1'b0;
`endif
        tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
        tbl[1] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FF00, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        tbl[4] = '{32'h0000_0080, 32'h0000_0080, 1'b0, 1'b1, 32'h0000_0100, 1'b0};
        tbl[5] = '{32'h0000_007F, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0080, 1'b0};
        tbl[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        tbl[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FF00, 1'b0};
        tbl[8] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_6789, 1'b0};
        tbl[9] = '{32'h0000_00C0, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0000, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 10; i++) run_vec(tbl[i]);
`ifdef APPROX_ADDER_ERRCNT_EN
        @(negedge clk);
        chk("err_cnt_after_table", err_cnt, err_exp);
`endif

        // Back-to-back 8 with a downstream stall at the start
        for (int i = 0; i < 8; i++) begin
            va[i] = rand_op(); vb[i] = rand_op(); vm[i] = 1'($urandom_range(0, 1));
        end
        rcv0 = rcv;
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0;
        drive(va[0], vb[0], 1'b0, vm[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            @(negedge clk);
            fire = in_ready;
            if (c == 6) begin
                chk("stall_accepted", idx, 4);
                chk("stall_in_ready", in_ready, 0);
            end
            @(posedge clk); #1;
            if (fire) idx++;
            if (idx < 8) drive(va[idx], vb[idx], 1'b1, vm[idx]);
            else in_valid = 1'b0;
            if (c >= 6) out_ready = 1'b1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stall_all_accepted", idx, 8);
        for (int c = 0; c < 20 && (rcv - rcv0) < 8; c++) @(posedge clk);
        #1;
        chk("stall_all_out", rcv - rcv0, 8);

        // Reset with 3 in flight and a 4th offered during reset
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(rand_op(), rand_op(), 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        drive(rand_op(), rand_op(), 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_sum", sum, 0);
        chk("flush_cout", cout, 0);
`ifdef APPROX_ADDER_ERRCNT_EN
        chk("flush_err_cnt", err_cnt, 0);
`endif
        rcv0 = rcv;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_no_stale", rcv - rcv0, 0);

        // Randomised traffic with random stalls and mixed modes
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);

`ifdef APPROX_ADDER_ERRCNT_EN
        // Counter saturation and clear
        @(posedge clk); #1;
        drive(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
        in_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (NSEG + 2) @(posedge clk);
        @(negedge clk);
        chk("err_cnt_sat", err_cnt, 16'hFFFF);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        err_exp = 0;
        @(negedge clk);
        chk("err_cnt_clr", err_cnt, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
